// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module : mult_div_unit_if
//  Brief  : Request/response bundle between the control unit and the
//           multi-cycle multiply/divide unit (operands, handshake, HI/LO).
//  Rev    : 1.0  initial release
// ============================================================================
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [5:0]       i_func_field;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic             o_div_by_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic [WIDTH-1:0] o_result;

  // Control-unit side: drives the request, observes status and HI/LO
  modport master (
    output i_start, i_func_field, i_a, i_b,
    input  o_busy, o_done, o_div_by_zero, o_hi, o_lo, o_result
  );

  // Unit side: consumes the request, produces status and HI/LO
  modport slave (
    input  i_start, i_func_field, i_a, i_b,
    output o_busy, o_done, o_div_by_zero, o_hi, o_lo, o_result
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module : mult_div_unit
//  Brief  : Iterative MIPS32 mult/multu/div/divu with HI/LO registers and
//           mfhi/mflo/mthi/mtlo. One product/quotient bit per cycle; signed
//           operations run on magnitudes and are sign-corrected in FIN.
//  Rev    : 1.0  initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_div_unit_if.slave bus
);

  localparam logic [5:0] C_F_MULT  = 6'h18;
  localparam logic [5:0] C_F_MULTU = 6'h19;
  localparam logic [5:0] C_F_DIV   = 6'h1A;
  localparam logic [5:0] C_F_DIVU  = 6'h1B;
  localparam logic [5:0] C_F_MFHI  = 6'h10;
  localparam logic [5:0] C_F_MTHI  = 6'h11;
  localparam logic [5:0] C_F_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_busy;

  logic [WIDTH-1:0]   r_cnt;      // remaining iterations
  logic [2*WIDTH-1:0] r_prod;     // MUL: {acc, multiplier}; DIV: {rem, quotient}
  logic [WIDTH-1:0]   r_opd;      // MUL: |multiplicand|; DIV: |divisor|
  logic               r_op_div;   // current operation is a divide
  logic               r_neg_res;  // operand signs differ
  logic               r_neg_rem;  // dividend was negative
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  // Request decode
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_is_mul = (bus.i_func_field == C_F_MULT) || (bus.i_func_field == C_F_MULTU);
  assign w_is_div = (bus.i_func_field == C_F_DIV)  || (bus.i_func_field == C_F_DIVU);
  assign w_signed = (bus.i_func_field == C_F_MULT) || (bus.i_func_field == C_F_DIV);
  assign w_a_neg  = w_signed & bus.i_a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.i_b[WIDTH-1];
  // The most-negative value maps onto itself, which is the correct unsigned magnitude
  assign w_a_mag  = w_a_neg ? (-bus.i_a) : bus.i_a;
  assign w_b_mag  = w_b_neg ? (-bus.i_b) : bus.i_b;

  // Shift-add step: add multiplicand on the current multiplier LSB, shift right
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_opd : '0)};
  assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder stays below the divisor, so bit WIDTH of the
  // difference is a clean borrow flag.
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_div_diff = r_prod[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};
  assign w_div_next = w_div_diff[WIDTH] ? {r_prod[2*WIDTH-2:0], 1'b0}
                                        : {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  // Sign correction of the raw magnitude results
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  assign w_prod_fix = r_neg_res ? (-r_prod) : r_prod;
  assign w_quo_fix  = r_neg_res ? (-r_prod[WIDTH-1:0]) : r_prod[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? (-r_prod[2*WIDTH-1:WIDTH]) : r_prod[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and busy decode
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start && w_is_mul)      w_next = S_MUL;
        else if (bus.i_start && w_is_div) w_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        w_busy = 1'b1;
        if (r_cnt == WIDTH'(1)) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write-back and moves to HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_prod    <= '0;
      r_opd     <= '0;
      r_op_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start && (w_is_mul || w_is_div)) begin
            r_cnt     <= WIDTH'(WIDTH);
            r_op_div  <= w_is_div;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dbz     <= 1'b0;
            if (w_is_mul) begin
              r_prod <= {{WIDTH{1'b0}}, w_b_mag};
              r_opd  <= w_a_mag;
            end else begin
              r_prod <= {{WIDTH{1'b0}}, w_a_mag};
              r_opd  <= w_b_mag;
            end
          end else if (bus.i_start && (bus.i_func_field == C_F_MTHI)) begin
            r_hi <= bus.i_a;
          end else if (bus.i_start && (bus.i_func_field == C_F_MTLO)) begin
            r_lo <= bus.i_a;
          end
        end
        S_MUL: begin
          r_prod <= w_mul_next;
          r_cnt  <= r_cnt - WIDTH'(1);
        end
        S_DIV: begin
          r_prod <= w_div_next;
          r_cnt  <= r_cnt - WIDTH'(1);
        end
        S_FIN: begin
          r_done <= 1'b1;
          if (r_op_div && (r_opd == '0)) begin
            // Remainder half already holds the unsigned dividend after a zero-divisor run
            r_lo  <= '1;
            r_hi  <= r_prod[2*WIDTH-1:WIDTH];
            r_dbz <= 1'b1;
          end else if (r_op_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_lo <= w_prod_fix[WIDTH-1:0];
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy        = w_busy;
  assign bus.o_done        = r_done;
  assign bus.o_div_by_zero = r_dbz;
  assign bus.o_hi          = r_hi;
  assign bus.o_lo          = r_lo;
  assign bus.o_result      = (bus.i_func_field == C_F_MFHI) ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, extending the combinational ALU with the MIPS32 `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo` operations. It takes operands from the register file alongside the ALU and is decoded from the same R-type `func_field`. It runs an iterative shift-add / restoring-divide datapath, one bit per cycle. A start/busy/done handshake lets the control unit stall the pipeline until HI/LO are valid.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- func_field  in  6  operation select: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo.
- A  in  WIDTH  rs operand (multiplicand / dividend / mthi/mtlo source).
- B  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse; HI/LO just updated by mult/div.
- div_by_zero  out  1  sticky until next accepted mult/div; set by div/divu with B=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- result  out  WIDTH  combinational: hi when func_field=0x10, else lo.

## Operation
- States: IDLE, MUL, DIV, FIN. Reset → IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, all internal registers cleared.
- Accept: IDLE and start=1.
  - func 0x18/0x19 → MUL; func 0x1A/0x1B → DIV.
  - Operands are latched on the accept edge, with a WIDTH-bit iteration counter loaded with WIDTH.
  - Any other func: no state change.
- Signed ops (mult/div):
  - Latch magnitudes |A| and |B| and record the signs.
  - Result correction in FIN: product negated (2·WIDTH-bit two's complement) if the signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
- MUL: 2·WIDTH-bit accumulator, shift-add one multiplier bit per cycle, counter decrements; at counter=1 → FIN.
- DIV: restoring division, one quotient bit per cycle.
  - Divisor=0 still iterates the full WIDTH cycles, then FIN forces lo={WIDTH{1}}, hi=A (latched dividend, unsigned form), div_by_zero=1.
  - Signed most-negative ÷ −1: lo=most-negative (wraps), hi=0, no flag.
- FIN: write hi (high product / remainder) and lo (low product / quotient), then → IDLE. done is high in the cycle after that write.
- mthi/mtlo: in IDLE with start=1, hi or lo ← A on that edge, with no busy and no done. Ignored in any non-IDLE state.
- start in MUL/DIV/FIN is ignored; operands are not re-latched.
- hi/lo are unchanged during iteration and hold their previous values until FIN.
- rst_n low at any time, including mid-iteration, aborts immediately to the reset values.

## Timing
- Accept edge = edge 0. busy is high after edge 0 through edge WIDTH, i.e. WIDTH cycles.
- FIN is entered on edge WIDTH. hi/lo are written on edge WIDTH+1, at which point busy=0 and done=1 for exactly one cycle.
- Accept→done latency: WIDTH+1 cycles. The next start can be accepted in the done cycle.
- div_by_zero updates on the FIN edge and clears on the next mult/div accept edge.
- result is purely combinational from func_field, hi and lo; there is no added latency.

## Test plan
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → busy high for 32 cycles; done on cycle 33 after accept; hi=0xFFFFFFFE, lo=0x00000001.
- mult A=0xFFFFFFFD (−3), B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; then mfhi/mflo put 0xFFFFFFFF/0xFFFFFFF1 on result.
- div A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 → lo=3, hi=1. div A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu A=0x1234, B=0 → after 33 cycles lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; the next multu 2×3 clears the flag, giving lo=6.
- mtlo A=0xABCD in IDLE → lo=0xABCD on the next edge, with no busy and no done. During a multu, start with mthi or with a new mult → ignored; the original result and latency are unchanged.
- rst_n pulsed low at cycle 10 of a mult → busy, done, hi, lo and div_by_zero are 0 immediately. After rst_n rises, multu 4×5 → lo=20 with full latency.
